mem_bus_arbiter: RTL and testbench

Two-master arbiter that shares one word-wide memory port between the instruction cache and the data cache miss/write-back ports (`dbOut_*` side of each cache). It grants the port to one cache and holds the grant for the entire block transfer, including a write-back that runs directly into a refill. It routes the memory `ready` strobe only to the owner and watches the owner for a stalled bus.

---
 rtl/mem_bus_arbiter.sv | 179 +++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// Two-master memory port arbiter: holds the grant for a whole block transfer and releases a stalled owner.
// Optional build macro MEM_ARB_ROUND_ROBIN_EN selects round-robin on simultaneous requests (default: master 0 wins).
`timescale 1ns/1ps
module mem_bus_arbiter #(
   parameter int TIMEOUT_CYCLES = 1023,
   parameter int TIMEOUT_WIDTH  = 10
) (
   input  logic        clk,
   input  logic        res,
   input  logic [31:0] m0_addr,
   input  logic [31:0] m0_dataOut,
   input  logic        m0_re,
   input  logic        m0_we,
   output logic [31:0] m0_dataIn,
   output logic        m0_ready,
   input  logic [31:0] m1_addr,
   input  logic [31:0] m1_dataOut,
   input  logic        m1_re,
   input  logic        m1_we,
   output logic [31:0] m1_dataIn,
   output logic        m1_ready,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_dataOut,
   output logic        mem_re,
   output logic        mem_we,
   input  logic [31:0] mem_dataIn,
   input  logic        mem_ready,
   output logic [1:0]  owner,
   output logic        busErr
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_GNT0  = 2'd1,
      S_GNT1  = 2'd2,
      S_DRAIN = 2'd3
   } state_t;

   localparam logic [TIMEOUT_WIDTH-1:0] STALL_LIMIT = TIMEOUT_WIDTH'(TIMEOUT_CYCLES);
   localparam logic [TIMEOUT_WIDTH-1:0] STALL_MAX   = {TIMEOUT_WIDTH{1'b1}};
   localparam logic [TIMEOUT_WIDTH-1:0] STALL_ONE   = TIMEOUT_WIDTH'(1);
   localparam logic [TIMEOUT_WIDTH-1:0] STALL_ZERO  = {TIMEOUT_WIDTH{1'b0}};

   state_t                   state_r;
   logic [1:0]               owner_r;
   logic                     bus_err_r;
   logic [TIMEOUT_WIDTH-1:0] stall_r;
   logic                     last_r;

   logic                     req0_s;
   logic                     req1_s;
   logic                     pick_s;
   logic                     cur_s;
   logic                     cur_req_s;
   logic                     oth_req_s;
   logic                     drain_req_s;
   logic                     timeout_s;
   logic [TIMEOUT_WIDTH-1:0] stall_inc_s;

   assign req0_s      = m0_re | m0_we;
   assign req1_s      = m1_re | m1_we;
   assign cur_s       = (state_r == S_GNT1);
   assign cur_req_s   = cur_s ? req1_s : req0_s;
   assign oth_req_s   = cur_s ? req0_s : req1_s;
   assign drain_req_s = last_r ? req1_s : req0_s;
   // Saturating increment; timeout fires when the next count would hit the limit.
   assign stall_inc_s = (stall_r == STALL_MAX) ? stall_r : (stall_r + STALL_ONE);
   assign timeout_s   = ~mem_ready & (stall_inc_s == STALL_LIMIT);

   assign owner  = owner_r;
   assign busErr = bus_err_r;

   // Choose which master leaves idle when one or both are requesting.
   always_comb begin
      pick_s = 1'b0;
      if (req0_s && req1_s) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
         pick_s = ~last_r;
`else
         pick_s = 1'b0;
`endif
      end else if (req1_s) begin
         pick_s = 1'b1;
      end else begin
         pick_s = 1'b0;
      end
   end

   // Grant state machine with registered owner, sticky error and stall counter.
   always_ff @(posedge clk or negedge res) begin
      if (!res) begin
         state_r   <= S_IDLE;
         owner_r   <= 2'b00;
         bus_err_r <= 1'b0;
         stall_r   <= STALL_ZERO;
         last_r    <= 1'b1;
      end else begin
         case (state_r)
            S_IDLE: begin
               if (req0_s || req1_s) begin
                  state_r <= pick_s ? S_GNT1 : S_GNT0;
                  owner_r <= pick_s ? 2'b10 : 2'b01;
                  last_r  <= pick_s;
                  stall_r <= STALL_ZERO;
               end else begin
                  state_r <= S_IDLE;
               end
            end
            S_GNT0, S_GNT1: begin
               if (!cur_req_s) begin
                  if (oth_req_s) begin
                     state_r <= cur_s ? S_GNT0 : S_GNT1;
                     owner_r <= cur_s ? 2'b01 : 2'b10;
                     last_r  <= ~cur_s;
                     stall_r <= STALL_ZERO;
                  end else begin
                     state_r <= S_IDLE;
                     owner_r <= 2'b00;
                  end
               end else if (timeout_s) begin
                  state_r   <= S_DRAIN;
                  owner_r   <= 2'b00;
                  bus_err_r <= 1'b1;
                  stall_r   <= stall_inc_s;
               end else if (mem_ready) begin
                  stall_r <= STALL_ZERO;
               end else begin
                  stall_r <= stall_inc_s;
               end
            end
            S_DRAIN: begin
               if (!drain_req_s) begin
                  state_r <= S_IDLE;
               end else begin
                  state_r <= S_DRAIN;
               end
            end
            default: begin
               state_r <= S_IDLE;
               owner_r <= 2'b00;
            end
         endcase
      end
   end

   // Forward the owner's request and route ready only to it; nothing passes in idle or drain.
   always_comb begin
      mem_addr    = 32'd0;
      mem_dataOut = 32'd0;
      mem_re      = 1'b0;
      mem_we      = 1'b0;
      m0_ready    = 1'b0;
      m1_ready    = 1'b0;
      case (state_r)
         S_GNT0: begin
            mem_addr    = m0_addr;
            mem_dataOut = m0_dataOut;
            mem_re      = m0_re;
            mem_we      = m0_we;
            m0_ready    = mem_ready;
         end
         S_GNT1: begin
            mem_addr    = m1_addr;
            mem_dataOut = m1_dataOut;
            mem_re      = m1_re;
            mem_we      = m1_we;
            m1_ready    = mem_ready;
         end
         default: begin
            mem_re = 1'b0;
            mem_we = 1'b0;
         end
      endcase
   end

   assign m0_dataIn = mem_dataIn;
   assign m1_dataIn = mem_dataIn;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: rule-level model checked every cycle plus hand-computed directed checks.
`timescale 1ns/1ps
module tb_mem_bus_arbiter;

   localparam int TO = 8;
`ifdef MEM_ARB_ROUND_ROBIN_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        res = 1'b0;
   logic [31:0] m0_addr = 32'd0, m0_dataOut = 32'd0, m1_addr = 32'd0, m1_dataOut = 32'd0;
   logic        m0_re = 1'b0, m0_we = 1'b0, m1_re = 1'b0, m1_we = 1'b0;
   logic [31:0] m0_dataIn, m1_dataIn, mem_addr, mem_dataOut;
   logic        m0_ready, m1_ready, mem_re, mem_we, busErr;
   logic [31:0] mem_dataIn = 32'd0;
   logic        mem_ready = 1'b0;
   logic [1:0]  owner;

   int n_vec = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   mem_bus_arbiter #(.TIMEOUT_CYCLES(TO), .TIMEOUT_WIDTH(4)) dut (
      .clk(clk), .res(res),
      .m0_addr(m0_addr), .m0_dataOut(m0_dataOut), .m0_re(m0_re), .m0_we(m0_we),
      .m0_dataIn(m0_dataIn), .m0_ready(m0_ready),
      .m1_addr(m1_addr), .m1_dataOut(m1_dataOut), .m1_re(m1_re), .m1_we(m1_we),
      .m1_dataIn(m1_dataIn), .m1_ready(m1_ready),
      .mem_addr(mem_addr), .mem_dataOut(mem_dataOut), .mem_re(mem_re), .mem_we(mem_we),
      .mem_dataIn(mem_dataIn), .mem_ready(mem_ready),
      .owner(owner), .busErr(busErr)
   );

   task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, got, exp);
      end
   endtask

   // Model: mo = owning master (-1 none), md = draining, me = sticky error, ml = last owner, ms = stall count.
   int mo = -1;
   bit md = 1'b0;
   bit me = 1'b0;
   int ml = 1;
   int ms = 0;
   bit rq[2];

   always begin
      @(posedge clk or negedge res);
      if (!res) begin
         mo = -1; md = 1'b0; me = 1'b0; ml = 1; ms = 0;
      end else begin
         rq[0] = m0_re | m0_we;
         rq[1] = m1_re | m1_we;
         if (md) begin
            if (!rq[ml]) md = 1'b0;
         end else if (mo < 0) begin
            if (rq[0] || rq[1]) begin
               if (rq[0] && rq[1]) mo = RR ? (1 - ml) : 0;
               else mo = rq[1] ? 1 : 0;
               ml = mo;
               ms = 0;
            end
         end else if (!rq[mo]) begin
            if (rq[1 - mo]) begin
               mo = 1 - mo; ml = mo; ms = 0;
            end else begin
               mo = -1;
            end
         end else if (mem_ready) begin
            ms = 0;
         end else begin
            ms++;
            if (ms == TO) begin
               me = 1'b1; md = 1'b1; mo = -1;
            end
         end
      end
   end

   always @(negedge clk) begin
      logic [1:0] e_own;
      logic e_re, e_we, e_r0, e_r1;
      e_own = (mo == 0) ? 2'b01 : (mo == 1) ? 2'b10 : 2'b00;
      e_re  = (mo == 0) ? m0_re : (mo == 1) ? m1_re : 1'b0;
      e_we  = (mo == 0) ? m0_we : (mo == 1) ? m1_we : 1'b0;
      e_r0  = (mo == 0) && mem_ready;
      e_r1  = (mo == 1) && mem_ready;
      chk("ctrl", {owner, busErr, mem_re, mem_we, m0_ready, m1_ready},
                  {e_own, me, e_re, e_we, e_r0, e_r1});
      chk("rdata", {m0_dataIn, m1_dataIn}, {mem_dataIn, mem_dataIn});
      if (mo >= 0)
         chk("fwd", {mem_addr, mem_dataOut},
             (mo == 0) ? {m0_addr, m0_dataOut} : {m1_addr, m1_dataOut});
   end

   task automatic tick();
      @(posedge clk);
      #1;
      mem_dataIn = $urandom;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: run did not reach the end in time");
      $fatal(1, "watchdog");
   end

   initial begin
      // reset state
      tick();
      @(negedge clk);
      chk("reset_state", {owner, busErr, mem_re, mem_we, m0_ready, m1_ready}, 8'h00);
      tick();
      res = 1'b1;

      // single master 1 read of four words
      tick();
      m1_re = 1'b1; m1_addr = 32'h0000_1000;
      @(negedge clk);
      chk("not_yet_granted", {30'd0, owner}, 32'd0);
      tick();
      @(negedge clk);
      chk("m1_grant", {owner, mem_re, mem_addr}, {2'b10, 1'b1, 32'h0000_1000});
      for (int k = 0; k < 4; k++) begin
         tick();
         mem_ready = 1'b1; m1_addr = 32'h0000_1000 + 32'(4 * k);
         @(negedge clk);
         chk("m1_ready_pulse", {m1_ready, m0_ready}, 2'b10);
         tick();
         mem_ready = 1'b0;
      end
      tick();
      m1_re = 1'b0;
      tick();
      @(negedge clk);
      chk("m1_release", {30'd0, owner}, 32'd0);

      // simultaneous requests after master 1 was last owner
      tick();
      m0_re = 1'b1; m1_re = 1'b1;
      tick();
      @(negedge clk);
      chk("sim_first", {30'd0, owner}, 32'd1);
      tick(); mem_ready = 1'b1;
      tick();
      tick(); m0_re = 1'b0; mem_ready = 1'b0;
      @(negedge clk);
      chk("handover_gap", {owner, mem_re, mem_we}, {2'b01, 1'b0, 1'b0});
      tick();
      @(negedge clk);
      chk("handover", {30'd0, owner}, 32'd2);
      tick(); m1_re = 1'b0;
      tick();

      // master 0 alone, then both: fixed priority keeps master 0, round-robin gives master 1
      tick(); m0_re = 1'b1;
      tick();
      tick(); m0_re = 1'b0;
      tick();
      tick(); m0_re = 1'b1; m1_re = 1'b1;
      tick();
      @(negedge clk);
      chk("sim_second", {30'd0, owner}, RR ? 32'd2 : 32'd1);
      tick(); m0_re = 1'b0; m1_re = 1'b0;
      tick();
      tick();

      // write-back running straight into refill while master 1 waits
      tick(); m0_we = 1'b1; mem_ready = 1'b1;
      tick(); m1_re = 1'b1; m1_addr = 32'h0000_4000;
      for (int i = 0; i < 256; i++) begin
         tick();
         m0_addr = 32'h0000_2000 + 32'(4 * i); m0_dataOut = 32'(i);
      end
      for (int i = 0; i < 256; i++) begin
         tick();
         m0_we = 1'b0; m0_re = 1'b1;
         m0_addr = 32'h0000_3000 + 32'(4 * i);
         if (i == 0) begin
            @(negedge clk);
            chk("wb_to_refill", {owner, mem_re, mem_we}, {2'b01, 1'b1, 1'b0});
         end
      end
      tick(); m0_re = 1'b0; mem_ready = 1'b0;
      @(negedge clk);
      chk("refill_end_gap", {owner, mem_re}, {2'b01, 1'b0});

      // master 1 owns, memory never answers: release after exactly TO owner cycles
      for (int k = 1; k <= TO; k++) begin
         tick();
         @(negedge clk);
         chk("stall_hold", {owner, busErr}, {2'b10, 1'b0});
      end
      for (int k = 0; k < 3; k++) begin
         tick();
         @(negedge clk);
         chk("drain", {owner, busErr, mem_re, m1_ready}, {2'b00, 1'b1, 1'b0, 1'b0});
      end
      tick(); m1_re = 1'b0;
      tick();
      @(negedge clk);
      chk("err_sticky", {owner, busErr}, {2'b00, 1'b1});

      // reset in the middle of a burst
      tick(); m0_re = 1'b1; mem_ready = 1'b1; m0_addr = 32'h0000_5000;
      for (int k = 0; k < 4; k++) tick();
      #2;
      res = 1'b0;
      #1;
      chk("async_reset", {owner, busErr, mem_re, m0_ready}, {2'b00, 1'b0, 1'b0, 1'b0});
      tick(); m0_re = 1'b0; mem_ready = 1'b0;
      tick(); res = 1'b1;
      @(negedge clk);
      chk("post_reset_idle", {30'd0, owner}, 32'd0);
      tick(); m1_re = 1'b1;
      tick();
      @(negedge clk);
      chk("post_reset_grant", {30'd0, owner}, 32'd2);
      tick(); m1_re = 1'b0;
      tick();
      tick();
      @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
